mc_ctrl: RTL and testbench

- Multicycle control unit for the dmips core; it is the producer of the 3-bit ALU control word the ALU consumes.
- A Moore FSM sequences fetch, decode, execute, memory and writeback for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
- It also decodes funct/aluop into alucont and stalls on a memory ready handshake.
- It sits between the instruction register and the datapath muxes, register file, PC and memory port.

---
 rtl/dmips_pkg.sv | 50 +++++
 rtl/mc_ctrl_if.sv | 39 +++
 rtl/alu_dec.sv | 28 ++
 rtl/mc_ctrl.sv | 151 +++++++++++++++
 tb/tb_mc_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmips_pkg.sv
// Shared dmips definitions: opcode/funct constants, ALU control encodings,
// aluop selector and the multicycle controller state enum.
package dmips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. Memory handshake: an access is in
// flight while mem_req is 1 and completes in the cycle where mem_ready is 1.
interface mc_ctrl_if #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6
);
  import dmips_pkg::*;

  logic [OP_WIDTH-1:0]    op;
  logic [FUNCT_WIDTH-1:0] funct;
  logic                   zero;
  logic                   mem_ready;
  logic                   mem_req;
  logic                   memwrite;
  logic                   irwrite;
  logic                   regwrite;
  logic                   pcen;
  logic                   iord;
  logic                   memtoreg;
  logic                   regdst;
  logic                   alusrca;
  logic [1:0]             alusrcb;
  logic [1:0]             pcsrc;
  logic [2:0]             alucont;
  logic                   illegal;
  state_t                 state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, irwrite, regwrite, pcen, iord, memtoreg,
           regdst, alusrca, alusrcb, pcsrc, alucont, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, irwrite, regwrite, pcen, iord, memtoreg,
           regdst, alusrca, alusrcb, pcsrc, alucont, illegal, state
  );
endinterface

// File: rtl/alu_dec.sv
// Combinational ALU decoder: aluop selects add/sub directly or defers to funct.
module alu_dec
  import dmips_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucont
);

  always_comb begin
    o_alucont = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB: o_alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucont = ALU_ADD;
          F_SUB:   o_alucont = ALU_SUB;
          F_AND:   o_alucont = ALU_AND;
          F_OR:    o_alucont = ALU_OR;
          F_SLT:   o_alucont = ALU_SLT;
          default: o_alucont = ALU_ADD;
        endcase
      end
      default: o_alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle dmips control FSM: Moore outputs decoded from state, with the
// memory-phase strobes qualified by mem_ready and beq's pcen by zero.
module mc_ctrl
  import dmips_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic  clk,
  input  logic  reset_n,
  mc_ctrl_if.master io
);

  state_t                 r_state;
  state_t                 w_next;
  logic [OP_WIDTH-1:0]    w_op;
  logic [FUNCT_WIDTH-1:0] w_funct;
  aluop_t                 w_aluop;
  logic [2:0]             w_alucont;
  logic w_mem_req, w_memwrite, w_irwrite, w_regwrite, w_pcen, w_illegal;
  logic w_iord, w_memtoreg, w_regdst, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;

  assign w_op    = io.op;
  assign w_funct = io.funct;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = io.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (w_op == OP_LW)      w_next = S_MEMRD;
        else if (w_op == OP_SW) w_next = S_MEMWR;
        else                    w_next = S_FETCH;
      end
      S_MEMRD:   w_next = io.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = io.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcen     = 1'b0;
    w_illegal  = 1'b0;
    w_iord     = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = io.mem_ready;
        w_pcen    = io.mem_ready;
      end
      S_DECODE: begin
        // ALUOut captures the branch target here for a following beq.
        w_alusrcb = 2'b11;
        w_illegal = !is_legal_op(w_op);
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = io.mem_ready;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_pcen    = io.zero;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .i_aluop   (w_aluop),
    .i_funct   (w_funct[5:0]),
    .o_alucont (w_alucont)
  );

  // Strobes are gated by reset_n so they drop without waiting for a clock edge.
  assign io.mem_req  = w_mem_req  & reset_n;
  assign io.memwrite = w_memwrite & reset_n;
  assign io.irwrite  = w_irwrite  & reset_n;
  assign io.regwrite = w_regwrite & reset_n;
  assign io.pcen     = w_pcen     & reset_n;
  assign io.illegal  = w_illegal  & reset_n;
  assign io.iord     = w_iord;
  assign io.memtoreg = w_memtoreg;
  assign io.regdst   = w_regdst;
  assign io.alusrca  = w_alusrca;
  assign io.alusrcb  = w_alusrcb;
  assign io.pcsrc    = w_pcsrc;
  assign io.alucont  = w_alucont;
  assign io.state    = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the FSM
// and checks state and control outputs cycle by cycle.
module tb_mc_ctrl;
  import dmips_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] exp_q[$];

  mc_ctrl_if u_if ();

  mc_ctrl #(.OP_WIDTH(6), .FUNCT_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    u_if.op = 6'd0; u_if.funct = 6'd0; u_if.zero = 1'b0; u_if.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (u_if.state !== S_FETCH) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", u_if.state, S_FETCH);
    end
    checks++;
    if ({u_if.mem_req, u_if.memwrite, u_if.irwrite, u_if.regwrite, u_if.pcen, u_if.illegal} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {u_if.mem_req, u_if.memwrite, u_if.irwrite, u_if.regwrite, u_if.pcen, u_if.illegal});
    end
    checks++;
    if ({u_if.iord, u_if.alusrca, u_if.alusrcb, u_if.pcsrc, u_if.alucont} !== 9'b0_0_01_00_010) begin
      failures++; $display("FAIL reset_selects got=%b exp=000100010",
        {u_if.iord, u_if.alusrca, u_if.alusrcb, u_if.pcsrc, u_if.alucont});
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if ({u_if.mem_req, u_if.irwrite, u_if.pcen} !== 3'b111) begin
      failures++; $display("FAIL fetch_after_release got=%b exp=111", {u_if.mem_req, u_if.irwrite, u_if.pcen});
    end
  endtask

  task automatic test_lw;
    logic [3:0] exp;
    u_if.op = OP_LW; u_if.mem_ready = 1'b1;
    exp_q = {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    for (int c = 1; c <= 6; c++) begin
      exp = exp_q.pop_front();
      checks++;
      if (u_if.state !== exp) begin
        failures++; $display("FAIL lw_state cyc%0d got=%0d exp=%0d", c, u_if.state, exp);
      end
      if (c == 3) begin
        checks++;
        if ({u_if.alusrca, u_if.alusrcb, u_if.alucont} !== 6'b1_10_010) begin
          failures++; $display("FAIL lw_memadr got=%b exp=110010", {u_if.alusrca, u_if.alusrcb, u_if.alucont});
        end
      end
      if (c == 4) begin
        checks++;
        if ({u_if.mem_req, u_if.iord, u_if.regwrite} !== 3'b110) begin
          failures++; $display("FAIL lw_memrd got=%b exp=110", {u_if.mem_req, u_if.iord, u_if.regwrite});
        end
      end
      if (c == 5) begin
        checks++;
        if ({u_if.regwrite, u_if.memtoreg, u_if.regdst, u_if.mem_req} !== 4'b1100) begin
          failures++; $display("FAIL lw_memwb got=%b exp=1100",
            {u_if.regwrite, u_if.memtoreg, u_if.regdst, u_if.mem_req});
        end
      end
      if (c < 6) tick();
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [2:0] exp_alu);
    u_if.op = OP_RTYPE; u_if.funct = f; u_if.mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (u_if.state !== S_RTYPEEX || u_if.alucont !== exp_alu || {u_if.alusrca, u_if.alusrcb} !== 3'b100) begin
      failures++; $display("FAIL rtype_ex funct=%b got state=%0d alucont=%b src=%b exp state=%0d alucont=%b src=100",
        f, u_if.state, u_if.alucont, {u_if.alusrca, u_if.alusrcb}, S_RTYPEEX, exp_alu);
    end
    tick();
    checks++;
    if (u_if.state !== S_RTYPEWB || {u_if.regwrite, u_if.regdst, u_if.memtoreg} !== 3'b110) begin
      failures++; $display("FAIL rtype_wb got state=%0d wr/dst/m2r=%b exp state=%0d 110",
        u_if.state, {u_if.regwrite, u_if.regdst, u_if.memtoreg}, S_RTYPEWB);
    end
    tick();
    checks++;
    if (u_if.state !== S_FETCH) begin
      failures++; $display("FAIL rtype_return got=%0d exp=%0d", u_if.state, S_FETCH);
    end
  endtask

  task automatic test_beq(input logic z);
    u_if.op = OP_BEQ; u_if.zero = z; u_if.mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (u_if.state !== S_BEQEX || u_if.pcsrc !== 2'b01 || u_if.pcen !== z || u_if.alucont !== ALU_SUB) begin
      failures++; $display("FAIL beq_ex zero=%b got state=%0d pcsrc=%b pcen=%b alucont=%b exp state=%0d 01 %b 110",
        z, u_if.state, u_if.pcsrc, u_if.pcen, u_if.alucont, S_BEQEX, z);
    end
    tick();
    checks++;
    if (u_if.state !== S_FETCH) begin
      failures++; $display("FAIL beq_return got=%0d exp=%0d", u_if.state, S_FETCH);
    end
    u_if.zero = 1'b0;
  endtask

  task automatic test_addi_j;
    u_if.op = OP_ADDI; u_if.mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (u_if.state !== S_ADDIEX || {u_if.alusrca, u_if.alusrcb, u_if.regwrite} !== 4'b1100) begin
      failures++; $display("FAIL addi_ex got state=%0d sel=%b exp state=%0d 1100",
        u_if.state, {u_if.alusrca, u_if.alusrcb, u_if.regwrite}, S_ADDIEX);
    end
    tick();
    checks++;
    if (u_if.state !== S_ADDIWB || {u_if.regwrite, u_if.regdst, u_if.memtoreg} !== 3'b100) begin
      failures++; $display("FAIL addi_wb got state=%0d wr/dst/m2r=%b exp state=%0d 100",
        u_if.state, {u_if.regwrite, u_if.regdst, u_if.memtoreg}, S_ADDIWB);
    end
    tick();
    u_if.op = OP_J;
    tick(); tick();
    checks++;
    if (u_if.state !== S_JEX || u_if.pcsrc !== 2'b10 || u_if.pcen !== 1'b1) begin
      failures++; $display("FAIL j_ex got state=%0d pcsrc=%b pcen=%b exp state=%0d 10 1",
        u_if.state, u_if.pcsrc, u_if.pcen, S_JEX);
    end
    tick();
    checks++;
    if (u_if.state !== S_FETCH) begin
      failures++; $display("FAIL j_return got=%0d exp=%0d", u_if.state, S_FETCH);
    end
  endtask

  task automatic test_sw_stall;
    int writes = 0;
    int reqs = 0;
    u_if.op = OP_SW; u_if.mem_ready = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      u_if.mem_ready = (i == 3);
      #1;
      checks++;
      if (u_if.state !== S_MEMWR || u_if.memwrite !== (i == 3)) begin
        failures++; $display("FAIL sw_memwr i=%0d got state=%0d memwrite=%b exp state=%0d memwrite=%b",
          i, u_if.state, u_if.memwrite, S_MEMWR, (i == 3));
      end
      if (u_if.mem_req === 1'b1) reqs++;
      if (u_if.memwrite === 1'b1) writes++;
      tick();
    end
    checks++;
    if (u_if.state !== S_FETCH || reqs != 4 || writes != 1) begin
      failures++; $display("FAIL sw_totals got state=%0d reqs=%0d writes=%0d exp state=%0d reqs=4 writes=1",
        u_if.state, reqs, writes, S_FETCH);
    end
    u_if.mem_ready = 1'b1;
  endtask

  task automatic test_illegal;
    u_if.op = 6'b111111; u_if.mem_ready = 1'b1;
    tick();
    checks++;
    if (u_if.state !== S_DECODE || u_if.illegal !== 1'b1 ||
        {u_if.regwrite, u_if.memwrite, u_if.pcen} !== 3'b000) begin
      failures++; $display("FAIL illegal_decode got state=%0d illegal=%b wr/mw/pcen=%b exp state=%0d 1 000",
        u_if.state, u_if.illegal, {u_if.regwrite, u_if.memwrite, u_if.pcen}, S_DECODE);
    end
    tick();
    checks++;
    if (u_if.state !== S_FETCH || u_if.illegal !== 1'b0) begin
      failures++; $display("FAIL illegal_return got state=%0d illegal=%b exp state=%0d 0",
        u_if.state, u_if.illegal, S_FETCH);
    end
  endtask

  task automatic test_reset_mid;
    u_if.op = OP_LW; u_if.mem_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (u_if.state !== S_MEMWB || u_if.regwrite !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got state=%0d regwrite=%b exp state=%0d 1",
        u_if.state, u_if.regwrite, S_MEMWB);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (u_if.regwrite !== 1'b0 || u_if.state !== S_FETCH || u_if.mem_req !== 1'b0) begin
      failures++; $display("FAIL midrst_async got regwrite=%b state=%0d mem_req=%b exp 0 %0d 0",
        u_if.regwrite, u_if.state, u_if.mem_req, S_FETCH);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (u_if.state !== S_FETCH || u_if.mem_req !== 1'b1) begin
      failures++; $display("FAIL midrst_release got state=%0d mem_req=%b exp %0d 1",
        u_if.state, u_if.mem_req, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype(F_SUB, ALU_SUB);
    test_rtype(F_SLT, ALU_SLT);
    test_rtype(6'b111111, ALU_ADD);
    test_rtype(F_OR, ALU_OR);
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi_j();
    test_sw_stall();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
